vend_controller: RTL and testbench
==================================

VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 Parameter PRICE, default 15, product price in credit units; multiple of 5, range 5..40.
REQ-002 Parameter TIMEOUT, default 255, idle cycles in COLLECT before automatic refund; range 2..255.
REQ-003 Parameter CREDIT_W, default 6, credit register width.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 arst  input  1  reset, asynchronous, active-high.
REQ-006 coin  input  3  coin code, sampled every cycle: 0 none, 1 = 5 units, 2 = 10 units, 4 = 25 units, other values invalid.
REQ-007 cancel  input  1  level, user refund request.
REQ-008 dispense_req  output  1  product dispense request to the vending mechanism.
REQ-009 dispense_ack  input  1  mechanism completed dispense.
REQ-010 change_valid  output  1  one 5-unit change coin offered.
REQ-011 change_ready  input  1  coin hopper accepts the offered coin.
REQ-012 credit  output  CREDIT_W  current credit, registered.
REQ-013 coin_reject  output  1  one-cycle pulse: coin not accepted.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 States SHALL be IDLE, COLLECT, DISPENSE, CHANGE; all outputs Moore or registered, no combinational input-to-output path.
REQ-016 IDLE/COLLECT, valid coin, cancel low: credit <= credit + value at the edge; next state DISPENSE if new credit >= PRICE, else COLLECT.
REQ-017 Invalid non-zero code, or any non-zero code in DISPENSE/CHANGE: credit unchanged, coin_reject high exactly the following cycle.
REQ-018 Cancel in COLLECT: next state CHANGE; coin in same cycle rejected per REQ-017 (cancel wins).
REQ-019 Cancel in IDLE, DISPENSE or CHANGE: ignored.
REQ-020 Idle timer: cleared on entering COLLECT and on every accepted coin; increments each COLLECT cycle otherwise; reaching TIMEOUT-1 moves to CHANGE next edge.
REQ-021 dispense_req = (state == DISPENSE); held until dispense_ack sampled high, no timeout.
REQ-022 DISPENSE with dispense_ack: credit <= credit - PRICE; next state IDLE if result 0, else CHANGE.
REQ-023 change_valid = (state == CHANGE) and credit != 0; each cycle with change_valid and change_ready, credit <= credit - 5.
REQ-024 CHANGE exits to IDLE the edge credit reaches 0; change_valid stays high across consecutive ready cycles (one coin per cycle).
REQ-025 Credit SHALL always be a multiple of 5; max credit = PRICE - 5 + 25 (35 at default), never wraps.
REQ-026 dispense_ack outside DISPENSE and change_ready outside CHANGE SHALL be ignored.
REQ-027 Latency: accepted coin to dispense_req high = 1 cycle; dispense_ack to first change_valid = 1 cycle.

Reset
REQ-028 arst high: state IDLE, credit 0, idle timer 0, coin_reject 0; hence dispense_req, change_valid, busy 0 immediately, without a clock edge.
REQ-029 Reset mid-DISPENSE or mid-CHANGE SHALL abort the transaction and discard credit; no refund after release.
REQ-030 First edge after arst release SHALL act as a normal IDLE cycle (a coin present is accepted).

Structure
REQ-031 Shared package vend_pkg: state enum, coin code constants, coin value constants (5/10/25), CHANGE_UNIT = 5.
REQ-032 Idle timer SHALL be sub-module vend_idle_timer (clk, arst, clear, enable, expired; TIMEOUT parameter).

Verification
REQ-033 Coins 1,1,1 in consecutive cycles -> credit 5,10,15; dispense_req high after third; ack -> credit 0, IDLE, no change_valid.
REQ-034 Coin 4 from IDLE -> credit 25, DISPENSE; ack -> credit 10; change_ready held high -> two change_valid cycles, credit 5 then 0, IDLE.
REQ-035 Coin 2, then cancel together with coin 1 -> coin_reject pulse, CHANGE, two coins refunded, credit 0.
REQ-036 Coin 1 then none for TIMEOUT cycles -> CHANGE, one coin refunded; code 3 in IDLE -> coin_reject, credit 0.
REQ-037 change_ready low 3 cycles in CHANGE -> change_valid stays high, credit held; coin 2 during DISPENSE -> rejected.
REQ-038 arst asserted mid-CHANGE with credit 10 -> change_valid, busy low same cycle; after release credit 0, IDLE.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: FSM states, coin codes and values.
package vend_pkg;

  localparam int unsigned COIN_W      = 3;
  localparam int unsigned VALUE_W     = 5;
  localparam int unsigned VAL_5       = 5;
  localparam int unsigned VAL_10      = 10;
  localparam int unsigned VAL_25      = 25;
  localparam int unsigned CHANGE_UNIT = 5;

  localparam logic [COIN_W-1:0] COIN_NONE = 3'd0;
  localparam logic [COIN_W-1:0] COIN_5    = 3'd1;
  localparam logic [COIN_W-1:0] COIN_10   = 3'd2;
  localparam logic [COIN_W-1:0] COIN_25   = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COLLECT  = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_CHANGE   = 2'd3
  } vend_state_t;

  // Credit value of a coin code; zero for no coin and for unknown codes.
  function automatic logic [VALUE_W-1:0] coin_value(input logic [COIN_W-1:0] code);
    logic [VALUE_W-1:0] v;
    v = '0;
    case (code)
      COIN_5:  v = VALUE_W'(VAL_5);
      COIN_10: v = VALUE_W'(VAL_10);
      COIN_25: v = VALUE_W'(VAL_25);
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic coin_is_valid(input logic [COIN_W-1:0] code);
    return (code == COIN_5) || (code == COIN_10) || (code == COIN_25);
  endfunction

endpackage

// File: rtl/vend_if.sv
// User/mechanism-side signal bundle of the vending controller.
interface vend_if #(
  parameter int unsigned CREDIT_W = 6
);
  import vend_pkg::*;

  logic [COIN_W-1:0]   coin;
  logic                cancel;
  logic                dispense_req;
  logic                dispense_ack;
  logic                change_valid;
  logic                change_ready;
  logic [CREDIT_W-1:0] credit;
  logic                coin_reject;
  logic                busy;

  // Environment side: coin slot, cancel button, mechanism and hopper.
  modport master (
    output coin, cancel, dispense_ack, change_ready,
    input  dispense_req, change_valid, credit, coin_reject, busy
  );

  // Controller side.
  modport slave (
    input  coin, cancel, dispense_ack, change_ready,
    output dispense_req, change_valid, credit, coin_reject, busy
  );

endinterface

// File: rtl/vend_idle_timer.sv
// Idle counter for the COLLECT state; flags expiry once it has counted TIMEOUT-1 cycles.
module vend_idle_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic arst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Saturates at LAST so expiry stays asserted until cleared.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/vend_controller.sv
// Coin-operated vending controller: collects credit, requests dispense, returns change in 5-unit coins.
module vend_controller
  import vend_pkg::*;
#(
  parameter int unsigned PRICE    = 15,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned CREDIT_W = 6
) (
  input  logic   clk,
  input  logic   arst,
  vend_if.slave  bus
);

  localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] UNIT_C     = CREDIT_W'(CHANGE_UNIT);
  localparam logic [CREDIT_W-1:0] MAX_CREDIT = CREDIT_W'(PRICE - CHANGE_UNIT + VAL_25);

  vend_state_t         state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                reject_q, reject_d;
  logic                coin_present;
  logic                coin_ok;
  logic                coin_accept;
  logic                timer_clear;
  logic                timer_en;
  logic                timer_expired;

  assign coin_present = (bus.coin != COIN_NONE);
  assign coin_ok      = coin_is_valid(bus.coin);

  vend_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk     (clk),
    .arst    (arst),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      reject_q <= reject_d;
    end
  end

  // Next state, next credit and coin reject decision.
  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    reject_d    = 1'b0;
    coin_accept = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Cancel is meaningless with no credit, so a coin is taken regardless.
        if (coin_ok) begin
          coin_accept = 1'b1;
          credit_d    = credit_q + CREDIT_W'(coin_value(bus.coin));
          state_d     = (credit_d >= PRICE_C) ? ST_DISPENSE : ST_COLLECT;
        end else begin
          reject_d = coin_present;
        end
      end

      ST_COLLECT: begin
        if (bus.cancel) begin
          reject_d = coin_present;
          state_d  = ST_CHANGE;
        end else if (coin_ok) begin
          coin_accept = 1'b1;
          credit_d    = credit_q + CREDIT_W'(coin_value(bus.coin));
          state_d     = (credit_d >= PRICE_C) ? ST_DISPENSE : ST_COLLECT;
        end else begin
          reject_d = coin_present;
          if (timer_expired) begin
            state_d = ST_CHANGE;
          end
        end
      end

      ST_DISPENSE: begin
        reject_d = coin_present;
        if (bus.dispense_ack) begin
          credit_d = credit_q - PRICE_C;
          state_d  = (credit_d == '0) ? ST_IDLE : ST_CHANGE;
        end
      end

      ST_CHANGE: begin
        reject_d = coin_present;
        if (credit_q == '0) begin
          state_d = ST_IDLE;
        end else if (bus.change_ready) begin
          credit_d = credit_q - UNIT_C;
          if (credit_d == '0) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d  = ST_IDLE;
        credit_d = '0;
      end
    endcase
  end

  // Timer restarts on every accepted coin and is held at zero outside COLLECT.
  assign timer_clear = coin_accept || (state_q != ST_COLLECT);
  assign timer_en    = (state_q == ST_COLLECT);

  // Moore outputs decoded from registered state and credit.
  always_comb begin
    bus.dispense_req = 1'b0;
    bus.change_valid = 1'b0;
    bus.busy         = 1'b0;
    bus.credit       = credit_q;
    bus.coin_reject  = reject_q;
    bus.dispense_req = (state_q == ST_DISPENSE);
    bus.change_valid = (state_q == ST_CHANGE) && (credit_q != '0);
    bus.busy         = (state_q != ST_IDLE);
  end

  a_credit_unit : assert property (@(posedge clk) disable iff (arst)
    (credit_q % UNIT_C) == '0);

  a_credit_max : assert property (@(posedge clk) disable iff (arst)
    credit_q <= MAX_CREDIT);

endmodule

// File: tb/tb_vend_controller.sv
// Directed checks of vend_controller with hand-computed expectations (PRICE 15, TIMEOUT 8).
module tb_vend_controller;
  import vend_pkg::*;

  localparam int unsigned PRICE    = 15;
  localparam int unsigned TIMEOUT  = 8;
  localparam int unsigned CREDIT_W = 6;

  logic tb_clk;
  logic arst;
  int   total;
  int   bad;

  vend_if #(.CREDIT_W(CREDIT_W)) vif ();

  vend_controller #(
    .PRICE    (PRICE),
    .TIMEOUT  (TIMEOUT),
    .CREDIT_W (CREDIT_W)
  ) dut (
    .clk  (tb_clk),
    .arst (arst),
    .bus  (vif)
  );

  initial begin
    tb_clk = 1'b0;
    forever #5 tb_clk = ~tb_clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic outs(input string tag, input int cr, input int bz, input int dr,
                      input int cv, input int rj);
    check({tag, ".credit"},       32'(vif.credit),       32'(cr));
    check({tag, ".busy"},         32'(vif.busy),         32'(bz));
    check({tag, ".dispense_req"}, 32'(vif.dispense_req), 32'(dr));
    check({tag, ".change_valid"}, 32'(vif.change_valid), 32'(cv));
    check({tag, ".coin_reject"},  32'(vif.coin_reject),  32'(rj));
  endtask

  // Apply inputs for one cycle and sample 1 time unit after the rising edge.
  task automatic tick(input int c, input int can, input int ack, input int rdy);
    vif.coin         = 3'(c);
    vif.cancel       = 1'(can);
    vif.dispense_ack = 1'(ack);
    vif.change_ready = 1'(rdy);
    @(posedge tb_clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    arst  = 1'b1;
    vif.coin         = '0;
    vif.cancel       = 1'b0;
    vif.dispense_ack = 1'b0;
    vif.change_ready = 1'b0;
    repeat (2) @(posedge tb_clk);
    #1;
    outs("reset", 0, 0, 0, 0, 0);
    arst = 1'b0;

    // Three 5-unit coins, first one on the edge right after reset release
    tick(1, 0, 0, 0); outs("c5",    5,  1, 0, 0, 0);
    tick(1, 0, 0, 0); outs("c10",   10, 1, 0, 0, 0);
    tick(1, 0, 0, 0); outs("c15",   15, 1, 1, 0, 0);
    tick(0, 0, 0, 0); outs("hold",  15, 1, 1, 0, 0);
    tick(0, 0, 1, 0); outs("ack15", 0,  0, 0, 0, 0);
    tick(0, 1, 1, 1); outs("idle_ign", 0, 0, 0, 0, 0);

    // 25 coin: dispense then two change coins with ready held
    tick(4, 0, 0, 0); outs("c25",   25, 1, 1, 0, 0);
    tick(0, 0, 1, 0); outs("ack25", 10, 1, 0, 1, 0);
    tick(0, 0, 0, 1); outs("chg1",  5,  1, 0, 1, 0);
    tick(0, 0, 0, 1); outs("chg2",  0,  0, 0, 0, 0);

    // Coin during DISPENSE rejected; hopper stall keeps change offered
    tick(4, 0, 0, 0); outs("d25",   25, 1, 1, 0, 0);
    tick(2, 0, 0, 0); outs("rej_d", 25, 1, 1, 0, 1);
    tick(0, 0, 0, 0); outs("rej_e", 25, 1, 1, 0, 0);
    tick(0, 0, 1, 0); outs("ackd",  10, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 0, 0); outs("stall", 10, 1, 0, 1, 0);
    end
    tick(0, 0, 0, 1); outs("st_c1", 5, 1, 0, 1, 0);
    tick(0, 0, 0, 1); outs("st_c2", 0, 0, 0, 0, 0);

    // Cancel together with a coin: coin rejected, credit refunded
    tick(2, 0, 0, 0); outs("cn10",  10, 1, 0, 0, 0);
    tick(1, 1, 0, 0); outs("cncl",  10, 1, 0, 1, 1);
    tick(0, 0, 0, 1); outs("rf1",   5,  1, 0, 1, 0);
    tick(0, 0, 0, 1); outs("rf2",   0,  0, 0, 0, 0);

    // Idle timeout after TIMEOUT empty cycles
    tick(1, 0, 0, 0); outs("to5",   5, 1, 0, 0, 0);
    for (int i = 0; i < int'(TIMEOUT) - 1; i++) tick(0, 0, 0, 0);
    outs("pre_to", 5, 1, 0, 0, 0);
    tick(0, 0, 0, 0); outs("to",    5, 1, 0, 1, 0);
    tick(0, 0, 0, 1); outs("to_rf", 0, 0, 0, 0, 0);

    // Invalid code in IDLE and in COLLECT
    tick(3, 0, 0, 0); outs("inv_i", 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0); outs("inv_e", 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0); outs("iv5",   5, 1, 0, 0, 0);
    tick(7, 0, 0, 0); outs("inv_c", 5, 1, 0, 0, 1);
    tick(2, 0, 0, 0); outs("iv15",  15, 1, 1, 0, 0);
    tick(0, 0, 1, 0); outs("ivack", 0,  0, 0, 0, 0);

    // Maximum credit PRICE-5+25 = 35
    tick(2, 0, 0, 0); outs("m10",   10, 1, 0, 0, 0);
    tick(4, 0, 0, 0); outs("m35",   35, 1, 1, 0, 0);
    tick(0, 0, 1, 0); outs("mack",  20, 1, 0, 1, 0);
    tick(0, 0, 0, 1); outs("m15",   15, 1, 0, 1, 0);
    tick(0, 0, 0, 1); outs("m10b",  10, 1, 0, 1, 0);
    tick(0, 0, 0, 1); outs("m5",    5,  1, 0, 1, 0);
    tick(0, 0, 0, 1); outs("m0",    0,  0, 0, 0, 0);

    // Asynchronous reset mid-CHANGE with credit 10
    tick(4, 0, 0, 0); outs("r25",   25, 1, 1, 0, 0);
    tick(0, 0, 1, 0); outs("r10",   10, 1, 0, 1, 0);
    vif.dispense_ack = 1'b0;
    #2 arst = 1'b1;
    #1 outs("arst_async", 0, 0, 0, 0, 0);
    @(posedge tb_clk);
    #1 arst = 1'b0;
    tick(0, 0, 0, 1); outs("post_rst", 0, 0, 0, 0, 0);
    tick(2, 0, 0, 0); outs("post_c",   10, 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
